histogram_bank_axi: RTL and testbench
=====================================

# histogram_bank_axi

Multi-channel, parametrised video histogram engine with a built-in AXI4-Lite read slave, running on a single clock. Per channel it accumulates pixels into one bank while the bank from the previous frame stays readable by the MicroBlaze. Banks swap on each frame boundary. It adds bin decimation, saturating counters, an automatic clear sweep, a dropped-pixel counter and frame status.

## Interface
- PIX_W, 8, pixel width per channel
- BIN_BITS, 8, log2 of bin count; bin = pixel >> (PIX_W-BIN_BITS); BIN_BITS ≤ PIX_W
- CH, 1, channel count (1..4); CH_BITS = max(1, clog2(CH))
- CNT_W, 20, bin counter width (≤ 32)
- ADDR_BITS, 12, AXI address width; must be ≥ CH_BITS+BIN_BITS+3
- clk  in  1  single clock for pixel path and AXI
- rst  in  1  asynchronous, active-high reset
- pix_i  in  CH*PIX_W  pixels; channel c occupies [c*PIX_W +: PIX_W]
- dv_i  in  1  pixel valid, common to all channels
- vs_i  in  1  vertical sync; its rising edge ends a frame
- s_axi_araddr  in  ADDR_BITS  read byte address
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  OKAY 2'b00 / SLVERR 2'b10
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready

## Operation
- Each channel has two banks, each 2^BIN_BITS × CNT_W. Bank pointer `act` selects the accumulating bank. The other bank is the completed bank.
- Pixel update: increment bin[act][bin(pix)] while dv_i=1. Counts saturate at 2^CNT_W-1 and never wrap.
- Frame end occurs on a registered rising edge of vs_i:
  - If no clear is running, toggle `act`, set VALID=1, increment FRAME_CNT (16-bit, wraps), and start a clear sweep of the new active bank.
  - If a clear is running, ignore the edge: no swap, FRAME_CNT unchanged.
- Clear sweep: zero one address per cycle across all channels, 2^BIN_BITS cycles, with BUSY=1.
  - Any dv_i=1 cycle during the sweep drops the pixel and increments DROP_CNT (16-bit, saturating).
- After reset: VALID=0 and a clear sweep of bank 0 runs (BUSY=1).
- Address map, byte-addressed, bits [1:0] ignored:
  - araddr[ADDR_BITS-1]=0: histogram read; word index {ch, bin} = araddr[CH_BITS+BIN_BITS+1:2]. Returns the completed bank's count, zero-extended. Returns 0 while VALID=0. ch ≥ CH gives SLVERR with rdata 0.
  - araddr[ADDR_BITS-1]=1, offset 0x0 STATUS: [31:16] FRAME_CNT, [1] BUSY, [0] VALID.
  - Offset 0x4: DROP_CNT in [15:0].
  - Any other register offset: SLVERR, rdata 0.
- Completed-bank selection is latched when the AR handshake completes. A swap during an outstanding read does not change the returned data.

## Timing
- Reset values: s_axi_arready=0, s_axi_rvalid=0, s_axi_rdata=0, s_axi_rresp=0. Internally `act`=0, VALID=0, FRAME_CNT=0, DROP_CNT=0.
- s_axi_arready=1 in the first cycle after reset release and whenever no read is outstanding. Exactly one read is outstanding at a time.
- AXI FSM:
  - IDLE → (arvalid & arready) → RD
  - RD → (1 cycle, RAM read) → RESP
  - RESP: rvalid=1, rdata/rresp held stable until rready; then → IDLE
- rvalid rises 2 cycles after the AR handshake. With rready=1, the next AR is accepted the cycle after rvalid falls.
- Pixel pipeline, per channel:
  - S0 registers pix/dv/bank tag.
  - S1 reads the RAM.
  - S2 writes count+1.
  - Forwarding from S1/S2 makes back-to-back same-bin pixels exact: N consecutive identical pixels add exactly N.
- In-flight pixels carry their bank tag. Pixels sampled before the vs_i edge land in the old bank even if the swap occurs mid-pipeline.
- Reset asserted mid-frame or mid-read aborts everything immediately. No partial AXI response is produced after reset release.

## Structure
- Package histogram_pkg holds:
  - register offsets STATUS=0x0, DROP=0x4
  - RESP_OKAY/RESP_SLVERR
  - CH_BITS derivation function
  - FSM state enum {IDLE, RD, RESP}
- Sub-module histogram_channel contains one channel's dual-bank RAM, the RMW pipeline with forwarding, the clear port and the AXI read port. It is instantiated CH times.
- The top level owns vs edge detection, `act`, the clear counter, status counters and the AXI FSM/mux.

## Test plan
- Wait out the reset clear sweep, then send 1 frame with CH=1 and pixels 0..255 each once, followed by a vs edge. Each bin reads 1, STATUS reads 0x00010001, and rvalid comes 2 cycles after the handshake.
- Send 1000 consecutive identical pixels 0x7F, then a vs edge. Bin 0x7F reads 1000 (forwarding check).
- CNT_W=4: send 20 pixels into the same bin. It reads 15 (saturation).
- Assert dv_i during the clear sweep for 10 cycles. DROP_CNT=10. A vs edge during the sweep leaves FRAME_CNT unchanged.
- CH=3: read channel 3 → SLVERR, rdata 0. Read an unmapped register offset 0x8 → SLVERR. Hold rready=0 for 5 cycles → rdata stays stable.
- Issue a read, pulse vs_i before rvalid, and confirm the returned data comes from the pre-swap bank. Assert reset mid-read → rvalid=0 and no response after release.

Source files
------------

// File: rtl/histogram_bank_axi_pkg.sv
// Shared constants, register map and AXI read FSM states for the histogram bank.
package histogram_pkg;

  localparam logic [31:0] REG_STATUS = 32'h0;
  localparam logic [31:0] REG_DROP   = 32'h4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RESP = 2'd2
  } axi_state_e;

  function automatic int ch_bits_of(input int ch);
    return (ch <= 1) ? 1 : $clog2(ch);
  endfunction

endpackage

// File: rtl/histogram_bank_axi_if.sv
// AXI4-Lite read channel bundle between the processor and the histogram bank.
interface histogram_bank_axi_if #(
  parameter int ADDR_BITS = 12
) ();
  logic [ADDR_BITS-1:0] s_axi_araddr;
  logic                 s_axi_arvalid;
  logic                 s_axi_arready;
  logic [31:0]          s_axi_rdata;
  logic [1:0]           s_axi_rresp;
  logic                 s_axi_rvalid;
  logic                 s_axi_rready;

  modport slave (
    input  s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport master (
    output s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
endinterface

// File: rtl/histogram_bank_axi_channel.sv
// One channel: two count banks, a read-modify-write pixel pipeline with forwarding,
// a clear write port and an asynchronous read port for the bus side.
module histogram_channel #(
  parameter int PIX_W    = 8,
  parameter int BIN_BITS = 8,
  parameter int CNT_W    = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PIX_W-1:0]    pix,
  input  logic                pix_en,
  input  logic                pix_bank,
  input  logic                clr_en,
  input  logic                clr_bank,
  input  logic [BIN_BITS-1:0] clr_addr,
  input  logic                rd_bank,
  input  logic [BIN_BITS-1:0] rd_bin,
  output logic [CNT_W-1:0]    rd_cnt
);

  localparam int NBINS = 1 << BIN_BITS;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] bank0 [NBINS];
  logic [CNT_W-1:0] bank1 [NBINS];

  logic                s0_dv, s0_bank;
  logic [BIN_BITS-1:0] s0_bin;
  logic                s1_dv, s1_bank;
  logic [BIN_BITS-1:0] s1_bin;
  logic [CNT_W-1:0]    s1_cnt;

  logic [CNT_W-1:0] s0_rd;
  logic [CNT_W-1:0] wr_cnt;
  logic             fwd;
  logic             unused_pix;

  assign unused_pix = ^pix;

  assign s0_rd  = s0_bank ? bank1[s0_bin] : bank0[s0_bin];
  assign wr_cnt = (s1_cnt == CNT_MAX) ? s1_cnt : s1_cnt + CNT_W'(1);
  // the write being committed this cycle is not yet visible in the array
  assign fwd    = s1_dv && (s1_bank == s0_bank) && (s1_bin == s0_bin);
  assign rd_cnt = rd_bank ? bank1[rd_bin] : bank0[rd_bin];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_dv   <= 1'b0;
      s0_bank <= 1'b0;
      s0_bin  <= '0;
      s1_dv   <= 1'b0;
      s1_bank <= 1'b0;
      s1_bin  <= '0;
      s1_cnt  <= '0;
    end else begin
      s0_dv   <= pix_en;
      s0_bank <= pix_bank;
      s0_bin  <= pix[PIX_W-1 -: BIN_BITS];
      s1_dv   <= s0_dv;
      s1_bank <= s0_bank;
      s1_bin  <= s0_bin;
      s1_cnt  <= fwd ? wr_cnt : s0_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_en && !clr_bank)
      bank0[clr_addr] <= '0;
    else if (s1_dv && !s1_bank)
      bank0[s1_bin] <= wr_cnt;
  end

  always_ff @(posedge clk) begin
    if (clr_en && clr_bank)
      bank1[clr_addr] <= '0;
    else if (s1_dv && s1_bank)
      bank1[s1_bin] <= wr_cnt;
  end

endmodule

// File: rtl/histogram_bank_axi.sv
// Multi-channel double-buffered histogram with frame swap, clear sweep,
// status counters and an AXI4-Lite read slave.
//
//   state | meaning
//   IDLE  | waiting for a read address, arready high
//   RD    | address latched, RAM/register read in progress
//   RESP  | rvalid high, rdata/rresp held until rready
module histogram_bank_axi
  import histogram_pkg::*;
#(
  parameter int PIX_W     = 8,
  parameter int BIN_BITS  = 8,
  parameter int CH        = 1,
  parameter int CNT_W     = 20,
  parameter int ADDR_BITS = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH*PIX_W-1:0] pix_i,
  input  logic                dv_i,
  input  logic                vs_i,
  histogram_bank_axi_if.slave s_axi
);

  localparam int CH_BITS  = ch_bits_of(CH);
  localparam int HIST_MSB = CH_BITS + BIN_BITS + 1;

  logic                vs_q;
  logic                act;
  logic                valid;
  logic [15:0]         frame_cnt;
  logic [15:0]         drop_cnt;
  logic                clr_busy;
  logic [BIN_BITS-1:0] clr_cnt;
  logic                swap;
  logic                accept;

  axi_state_e             state, state_nxt;
  logic                   ar_en;
  logic                   ar_fire;
  logic [ADDR_BITS-1:2]   ar_addr_q;
  logic                   ar_bank_q;
  logic                   ar_valid_q;
  logic [CH_BITS-1:0]     hist_ch;
  logic [BIN_BITS-1:0]    hist_bin;
  logic [ADDR_BITS-2:0]   reg_off;
  logic [CNT_W-1:0]       hist_cnt;
  logic [31:0]            resp_data;
  logic [1:0]             resp_code;
  logic [CNT_W-1:0]       ch_cnt [CH];
  logic                   unused_addr_lsb;

  assign unused_addr_lsb = ^s_axi.s_axi_araddr[1:0];

  // an edge seen while a clear is still running is dropped entirely
  assign swap   = vs_i & ~vs_q & ~clr_busy;
  assign accept = dv_i & ~clr_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q      <= 1'b0;
      act       <= 1'b0;
      valid     <= 1'b0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
      clr_busy  <= 1'b1;
      clr_cnt   <= '1;
    end else begin
      vs_q <= vs_i;
      if (swap) begin
        act       <= ~act;
        valid     <= 1'b1;
        frame_cnt <= frame_cnt + 16'd1;
        clr_busy  <= 1'b1;
        clr_cnt   <= '1;
      end else if (clr_busy) begin
        if (clr_cnt == '0)
          clr_busy <= 1'b0;
        else
          clr_cnt <= clr_cnt - BIN_BITS'(1);
      end
      if (dv_i && clr_busy && (drop_cnt != 16'hFFFF))
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    histogram_channel #(
      .PIX_W    (PIX_W),
      .BIN_BITS (BIN_BITS),
      .CNT_W    (CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .pix      (pix_i[c*PIX_W +: PIX_W]),
      .pix_en   (accept),
      .pix_bank (act),
      .clr_en   (clr_busy),
      .clr_bank (act),
      .clr_addr (clr_cnt),
      .rd_bank  (ar_bank_q),
      .rd_bin   (hist_bin),
      .rd_cnt   (ch_cnt[c])
    );
  end

  assign ar_fire  = s_axi.s_axi_arvalid & s_axi.s_axi_arready;
  assign hist_ch  = ar_addr_q[HIST_MSB:BIN_BITS+2];
  assign hist_bin = ar_addr_q[BIN_BITS+1:2];
  assign reg_off  = {ar_addr_q[ADDR_BITS-2:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ar_fire) state_nxt = RD;
      RD:      state_nxt = RESP;
      RESP:    if (s_axi.s_axi_rready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_axi.s_axi_arready = 1'b0;
    s_axi.s_axi_rvalid  = 1'b0;
    case (state)
      IDLE:    s_axi.s_axi_arready = ar_en;
      RESP:    s_axi.s_axi_rvalid  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    resp_data = '0;
    resp_code = RESP_OKAY;
    hist_cnt  = '0;
    for (int c = 0; c < CH; c++)
      if (int'(hist_ch) == c) hist_cnt = ch_cnt[c];
    if (ar_addr_q[ADDR_BITS-1]) begin
      if (reg_off == REG_STATUS[ADDR_BITS-2:0])
        resp_data = {frame_cnt, 14'd0, clr_busy, valid};
      else if (reg_off == REG_DROP[ADDR_BITS-2:0])
        resp_data = {16'd0, drop_cnt};
      else
        resp_code = RESP_SLVERR;
    end else if (int'(hist_ch) < CH) begin
      if (ar_valid_q) resp_data = 32'(hist_cnt);
    end else begin
      resp_code = RESP_SLVERR;
    end
  end

  // bank and VALID are frozen at the handshake so a swap cannot alter an outstanding read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_en             <= 1'b0;
      ar_addr_q         <= '0;
      ar_bank_q         <= 1'b0;
      ar_valid_q        <= 1'b0;
      s_axi.s_axi_rdata <= '0;
      s_axi.s_axi_rresp <= RESP_OKAY;
    end else begin
      ar_en <= 1'b1;
      if (ar_fire) begin
        ar_addr_q  <= s_axi.s_axi_araddr[ADDR_BITS-1:2];
        ar_bank_q  <= ~act;
        ar_valid_q <= valid;
      end
      if (state == RD) begin
        s_axi.s_axi_rdata <= resp_data;
        s_axi.s_axi_rresp <= resp_code;
      end
    end
  end

endmodule

// File: tb/tb_histogram_bank_axi.sv
// Scoreboard bench for histogram_bank_axi: directed frames, register reads,
// swap-during-read and reset-during-read scenarios.
module tb_histogram_bank_axi;

  localparam int PIX_W     = 8;
  localparam int BIN_BITS  = 8;
  localparam int CH        = 3;
  localparam int CNT_W     = 10;
  localparam int ADDR_BITS = 13;

  localparam logic [ADDR_BITS-1:0] A_STATUS = 13'h1000;
  localparam logic [ADDR_BITS-1:0] A_DROP   = 13'h1004;
  localparam logic [ADDR_BITS-1:0] A_BAD    = 13'h1008;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLV  = 2'b10;
  localparam logic [31:0] CNT_SAT = (32'd1 << CNT_W) - 32'd1;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    int          hs;
    string       name;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [CH*PIX_W-1:0] pix = '0;
  logic              dv = 1'b0;
  logic              vs = 1'b0;
  int                cyc = 0;
  int                checks = 0;
  int                errors = 0;
  exp_t              exp_q[$];
  bit                rv_seen = 1'b0;
  int                rv_first = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  histogram_bank_axi_if #(.ADDR_BITS(ADDR_BITS)) axi ();

  histogram_bank_axi #(
    .PIX_W(PIX_W), .BIN_BITS(BIN_BITS), .CH(CH), .CNT_W(CNT_W), .ADDR_BITS(ADDR_BITS)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .pix_i (pix),
    .dv_i  (dv),
    .vs_i  (vs),
    .s_axi (axi.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, want);
    end
  endtask

  function automatic logic [ADDR_BITS-1:0] haddr(input int ch, input int bin);
    int a;
    a = (ch << (BIN_BITS + 2)) | (bin << 2);
    return a[ADDR_BITS-1:0];
  endfunction

  task automatic vs_pulse();
    vs = 1'b1;
    step();
    vs = 1'b0;
    step();
  endtask

  task automatic axi_read(input logic [ADDR_BITS-1:0] addr, input logic [31:0] ed,
                          input logic [1:0] er, input string nm,
                          input int hold = 0, input bit pulse_vs = 1'b0);
    exp_t e;
    int   n;
    axi.s_axi_rready  = (hold == 0);
    axi.s_axi_araddr  = addr;
    axi.s_axi_arvalid = 1'b1;
    n = 0;
    while (!axi.s_axi_arready && n < 20) begin step(); n++; end
    if (!axi.s_axi_arready) begin
      checks++; errors++;
      $display("FAIL %s: arready timeout", nm);
      axi.s_axi_arvalid = 1'b0;
      return;
    end
    e.data = ed; e.resp = er; e.hs = cyc; e.name = nm;
    exp_q.push_back(e);
    if (pulse_vs) vs = 1'b1;
    step();
    axi.s_axi_arvalid = 1'b0;
    vs = 1'b0;
    if (hold > 0) begin
      n = 0;
      while (!axi.s_axi_rvalid && n < 10) begin step(); n++; end
      repeat (hold) step();
      axi.s_axi_rready = 1'b1;
    end
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin step(); n++; end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s: no response within bound", nm);
      exp_q.delete();
    end
    axi.s_axi_rready = 1'b1;
  endtask

  always @(negedge clk) begin
    if (axi.s_axi_rvalid) begin
      if (!rv_seen) begin
        rv_seen  = 1'b1;
        rv_first = cyc;
      end
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rvalid: got rdata 0x%08h with no read pending", axi.s_axi_rdata);
      end else begin
        chk({exp_q[0].name, "_data"}, axi.s_axi_rdata, exp_q[0].data);
        if (axi.s_axi_rready) begin
          chk({exp_q[0].name, "_resp"}, 32'(axi.s_axi_rresp), 32'(exp_q[0].resp));
          chk({exp_q[0].name, "_latency"}, 32'(rv_first - exp_q[0].hs), 32'd2);
          void'(exp_q.pop_front());
          rv_seen = 1'b0;
        end
      end
    end else begin
      rv_seen = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    axi.s_axi_araddr  = '0;
    axi.s_axi_arvalid = 1'b0;
    axi.s_axi_rready  = 1'b1;
    repeat (3) step();
    chk("rst_arready", 32'(axi.s_axi_arready), 32'd0);
    chk("rst_rvalid",  32'(axi.s_axi_rvalid),  32'd0);
    chk("rst_rdata",   axi.s_axi_rdata,        32'd0);
    chk("rst_rresp",   32'(axi.s_axi_rresp),   32'd0);
    rst = 1'b0;
    step();
    chk("arready_after_rst", 32'(axi.s_axi_arready), 32'd1);

    // reset clear sweep: busy, not valid, dropped pixels, ignored vs edge
    axi_read(A_STATUS, 32'h0000_0002, OKAY, "status_rst_sweep");
    axi_read(haddr(0, 5), 32'd0, OKAY, "hist_before_valid");
    pix = 24'h123456;
    dv  = 1'b1;
    repeat (10) step();
    dv = 1'b0;
    vs_pulse();
    repeat (300) step();
    axi_read(A_STATUS, 32'h0000_0000, OKAY, "status_vs_ignored");
    axi_read(A_DROP, 32'd10, OKAY, "drop_cnt");

    // frame 1: ch0 ramp, ch1 reverse ramp, ch2 constant 0x40
    for (int i = 0; i < 256; i++) begin
      pix = {8'h40, 8'(255 - i), 8'(i)};
      dv  = 1'b1;
      step();
    end
    dv = 1'b0;
    repeat (4) step();
    vs_pulse();
    axi_read(A_STATUS, 32'h0001_0003, OKAY, "status_f1_busy");
    repeat (300) step();
    axi_read(A_STATUS, 32'h0001_0001, OKAY, "status_f1");
    axi_read(haddr(0, 8'h00), 32'd1, OKAY, "f1_ch0_b00");
    axi_read(haddr(0, 8'h7F), 32'd1, OKAY, "f1_ch0_b7f");
    axi_read(haddr(0, 8'hFF), 32'd1, OKAY, "f1_ch0_bff");
    axi_read(haddr(1, 8'h10), 32'd1, OKAY, "f1_ch1_b10");
    axi_read(haddr(2, 8'h40), 32'd256, OKAY, "f1_ch2_b40");
    axi_read(haddr(2, 8'h41), 32'd0, OKAY, "f1_ch2_b41");
    axi_read(haddr(3, 8'h00), 32'd0, SLV, "ch3_slverr");
    axi_read(A_BAD, 32'd0, SLV, "reg_08_slverr");

    // frame 2: 1000 x 0x7F on ch0, alternating bins on ch1, saturation on ch2
    for (int i = 0; i < 1030; i++) begin
      pix = {8'h03, ((i % 2) != 0) ? 8'h80 : 8'h7F, (i < 1000) ? 8'h7F : 8'h00};
      dv  = 1'b1;
      step();
    end
    dv = 1'b0;
    repeat (4) step();
    vs_pulse();
    repeat (300) step();
    axi_read(A_STATUS, 32'h0002_0001, OKAY, "status_f2");
    axi_read(haddr(0, 8'h7F), 32'd1000, OKAY, "f2_ch0_b7f");
    axi_read(haddr(0, 8'h00), 32'd30, OKAY, "f2_ch0_b00");
    axi_read(haddr(0, 8'h01), 32'd0, OKAY, "f2_ch0_b01");
    axi_read(haddr(1, 8'h7F), 32'd515, OKAY, "f2_ch1_b7f");
    axi_read(haddr(1, 8'h80), 32'd515, OKAY, "f2_ch1_b80");
    axi_read(haddr(2, 8'h03), CNT_SAT, OKAY, "f2_ch2_sat");
    axi_read(haddr(2, 8'h03), CNT_SAT, OKAY, "hold_rready", 5);

    // frame 3 with a swap landing in the same cycle as the read handshake
    pix = 24'h7F7F7F;
    dv  = 1'b1;
    repeat (5) step();
    dv = 1'b0;
    repeat (4) step();
    axi_read(haddr(0, 8'h7F), 32'd1000, OKAY, "preswap_read", 0, 1'b1);
    repeat (300) step();
    axi_read(A_STATUS, 32'h0003_0001, OKAY, "status_f3");
    axi_read(haddr(0, 8'h7F), 32'd5, OKAY, "f3_ch0_b7f");

    // reset during an outstanding read: no response may follow
    axi.s_axi_araddr  = haddr(0, 8'h7F);
    axi.s_axi_arvalid = 1'b1;
    step();
    axi.s_axi_arvalid = 1'b0;
    rst = 1'b1;
    step();
    chk("midrd_rst_rvalid", 32'(axi.s_axi_rvalid), 32'd0);
    chk("midrd_rst_rdata",  axi.s_axi_rdata,       32'd0);
    repeat (2) step();
    rst = 1'b0;
    repeat (10) step();
    chk("midrd_rvalid_after", 32'(axi.s_axi_rvalid), 32'd0);
    chk("midrd_arready_after", 32'(axi.s_axi_arready), 32'd1);
    axi_read(A_STATUS, 32'h0000_0002, OKAY, "status_after_rst2");
    axi_read(A_DROP, 32'd0, OKAY, "drop_after_rst2");

    repeat (5) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
